// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC and
// keeps at most one request outstanding to a variable-latency instruction
// memory.
//
// Handshake: imem_req is a one-cycle pulse; the memory captures imem_addr in
// that cycle. Exactly one imem_valid strobe (with imem_rdata) comes back one or
// more cycles later. The unit never raises imem_req again until that strobe has
// been seen, so it needs no ready signal. A strobe seen in ISSUE or HOLD is a
// protocol error: it is ignored, and an assertion flags it in simulation.
//
// Optional feature: define FETCH_PERF_CNT_EN to add the FetchCountF and
// StallCountF performance counters.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   StallF              hold the current fetch, do not advance the PC
//   PCSrcE, PCTargetE   redirect from Execute (target used unmodified)
//   imem_req/imem_addr  request pulse and address (= PCF)
//   imem_rdata/valid    response data and one-cycle strobe
//   InstrF              fetched instruction, or NOP_INSTR when none is valid
//   PCF, PCPlus4F       PC of InstrF and PC+4 (wraps)
//   InstrValidF         InstrF holds a real instruction this cycle
//   FetchBusyF          !InstrValidF
//   FetchCountF         (FETCH_PERF_CNT_EN) accepted instructions
//   StallCountF         (FETCH_PERF_CNT_EN) valid cycles with StallF high
//   dbg_state           current FSM state, for observation
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned               DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]     RESET_VECTOR = '0,
  parameter logic [DATA_WIDTH-1:0]     NOP_INSTR    = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  imem_valid,
  output logic [DATA_WIDTH-1:0] InstrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  InstrValidF,
  output logic                  FetchBusyF,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]           FetchCountF,
  output logic [31:0]           StallCountF,
`endif
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] ISSUE   = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  logic [1:0]            state, state_nxt;
  logic [DATA_WIDTH-1:0] pc, pc_nxt, pc_plus4;
  logic [DATA_WIDTH-1:0] hold_buf;
  logic [DATA_WIDTH-1:0] instr;
  logic                  hold_load;
  logic                  instr_valid;
  logic                  req;
  logic                  accept;   // valid instruction consumed, PC advances

  assign pc_plus4 = pc + DATA_WIDTH'(4);

  // Redirect always wins over stall and normal advance.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    hold_load   = 1'b0;
    instr_valid = 1'b0;
    instr       = NOP_INSTR;
    req         = 1'b0;
    accept      = 1'b0;
    case (state)
      ISSUE: begin
        if (PCSrcE) begin
          pc_nxt = PCTargetE;
        end else begin
          req       = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (PCSrcE) begin
          // Response in this cycle is dropped; otherwise it is still in
          // flight and DISCARD swallows it.
          pc_nxt    = PCTargetE;
          state_nxt = imem_valid ? ISSUE : DISCARD;
        end else if (imem_valid) begin
          instr_valid = 1'b1;
          instr       = imem_rdata;
          if (StallF) begin
            hold_load = 1'b1;
            state_nxt = HOLD;
          end else begin
            accept    = 1'b1;
            pc_nxt    = pc_plus4;
            state_nxt = ISSUE;
          end
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          pc_nxt    = PCTargetE;
          state_nxt = ISSUE;
        end else begin
          instr_valid = 1'b1;
          instr       = hold_buf;
          if (!StallF) begin
            accept    = 1'b1;
            pc_nxt    = pc_plus4;
            state_nxt = ISSUE;
          end
        end
      end
      DISCARD: begin
        // Newest redirect target wins while the stale response drains.
        if (PCSrcE) pc_nxt = PCTargetE;
        if (imem_valid) state_nxt = ISSUE;
      end
      default: state_nxt = ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ISSUE;
      pc       <= RESET_VECTOR;
      hold_buf <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (hold_load) hold_buf <= imem_rdata;
    end
  end

  // Outputs are forced quiet while reset is held, whatever the state register.
  assign imem_req    = req & ~rst;
  assign imem_addr   = pc;
  assign InstrValidF = instr_valid & ~rst;
  assign InstrF      = InstrValidF ? instr : NOP_INSTR;
  assign FetchBusyF  = ~InstrValidF;
  assign PCF         = pc;
  assign PCPlus4F    = pc_plus4;
  assign dbg_state   = state;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      FetchCountF <= '0;
      StallCountF <= '0;
    end else begin
      if (accept) FetchCountF <= FetchCountF + 32'd1;
      if (InstrValidF && StallF) StallCountF <= StallCountF + 32'd1;
    end
  end
`endif

  // A response strobe is only legal while a request is outstanding.
  a_no_stray_valid: assert property (@(posedge clk) disable iff (rst)
    !(imem_valid && (state == ISSUE || state == HOLD)));

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. A small memory responder answers each request
// after mem_lat cycles with (address ^ mem_xor). Inputs change 1 time unit
// after the rising edge; outputs are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        InstrValidF;
  logic        FetchBusyF;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCountF;
  logic [31:0] StallCountF;
`endif

  int checks = 0;
  int errors = 0;

  // memory responder configuration
  int          mem_lat    = 1;
  logic [31:0] mem_xor    = '0;
  logic        mem_rst_en = 1'b1;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .StallF      (StallF),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .InstrF      (InstrF),
    .PCF         (PCF),
    .PCPlus4F    (PCPlus4F),
    .InstrValidF (InstrValidF),
    .FetchBusyF  (FetchBusyF),
`ifdef FETCH_PERF_CNT_EN
    .FetchCountF (FetchCountF),
    .StallCountF (StallCountF),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- memory responder ----------------
  initial begin : mem_model
    logic        s_req, s_rst;
    logic [31:0] s_addr, mem_addr;
    int          mem_cnt;
    imem_valid = 1'b0;
    imem_rdata = '0;
    mem_addr   = '0;
    mem_cnt    = 0;
    forever begin
      @(negedge clk);
      s_req  = imem_req;
      s_addr = imem_addr;
      s_rst  = rst;
      @(posedge clk);
      #1;
      imem_valid = 1'b0;
      if (s_rst && mem_rst_en) begin
        mem_cnt = 0;
      end else begin
        if (s_req) begin
          mem_addr = s_addr;
          mem_cnt  = mem_lat;
        end
        if (mem_cnt > 0) begin
          mem_cnt--;
          if (mem_cnt == 0) begin
            imem_valid = 1'b1;
            imem_rdata = mem_addr ^ mem_xor;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) next_cycle();
  endtask

  // Leaves the bench 1 unit into cycle c0: first ISSUE cycle after reset.
  task automatic apply_reset(input int lat, input logic [31:0] x);
    mem_lat = lat;
    mem_xor = x;
    StallF  = 1'b0;
    PCSrcE  = 1'b0;
    rst     = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({imem_req, InstrValidF, FetchBusyF, InstrF} !== {1'b0, 1'b0, 1'b1, NOP}) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b vld=%b busy=%b instr=%h expected 0 0 1 %h",
               imem_req, InstrValidF, FetchBusyF, InstrF, NOP);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_req, imem_addr, PCF, PCPlus4F, InstrValidF, dbg_state} !==
        {1'b1, 32'h0, 32'h0, 32'h4, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_first_issue: got req=%b addr=%h pc=%h pc4=%h vld=%b st=%0d expected 1 0 0 4 0 0",
               imem_req, imem_addr, PCF, PCPlus4F, InstrValidF, dbg_state);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if ({FetchCountF, StallCountF} !== 64'h0) begin
      errors++;
      $display("FAIL reset_counters: got fetch=%0d stall=%0d expected 0 0", FetchCountF, StallCountF);
    end
`endif
    next_cycle();
  endtask

  task automatic test_latency1;
    apply_reset(1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({imem_req, imem_addr, InstrValidF, InstrF} !== {1'b1, 32'(4 * i), 1'b0, NOP}) begin
        errors++;
        $display("FAIL lat1_issue[%0d]: got req=%b addr=%h vld=%b instr=%h expected 1 %h 0 %h",
                 i, imem_req, imem_addr, InstrValidF, InstrF, 32'(4 * i), NOP);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if ({imem_req, InstrValidF, FetchBusyF, InstrF, PCF, PCPlus4F} !==
          {1'b0, 1'b1, 1'b0, 32'(4 * i), 32'(4 * i), 32'(4 * i + 4)}) begin
        errors++;
        $display("FAIL lat1_valid[%0d]: got req=%b vld=%b busy=%b instr=%h pc=%h pc4=%h expected 0 1 0 %h %h %h",
                 i, imem_req, InstrValidF, FetchBusyF, InstrF, PCF, PCPlus4F,
                 32'(4 * i), 32'(4 * i), 32'(4 * i + 4));
      end
      next_cycle();
    end
  endtask

  task automatic test_stall;
    apply_reset(3, 32'h1234_0000);
    cycles(3);                       // c3: response arrives
    StallF = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j == 4) StallF = 1'b0;
      @(negedge clk);
      checks++;
      if ({imem_req, InstrValidF, InstrF, PCF} !== {1'b0, 1'b1, 32'h1234_0000, 32'h0}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got req=%b vld=%b instr=%h pc=%h expected 0 1 12340000 0",
                 j, imem_req, InstrValidF, InstrF, PCF);
      end
      if (j == 1) begin
        checks++;
        if (dbg_state !== 2'd2) begin
          errors++;
          $display("FAIL stall_state: got %0d expected 2", dbg_state);
        end
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if ({imem_req, imem_addr, InstrValidF} !== {1'b1, 32'h4, 1'b0}) begin
      errors++;
      $display("FAIL stall_next_req: got req=%b addr=%h vld=%b expected 1 4 0",
               imem_req, imem_addr, InstrValidF);
    end
  endtask

  task automatic test_redirect_wait;
    apply_reset(3, 32'h00AB_0000);
    cycles(8);                       // c8: request to 0x8
    @(negedge clk);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
      errors++;
      $display("FAIL redir_req8: got req=%b addr=%h expected 1 8", imem_req, imem_addr);
    end
    next_cycle();                    // c9: redirect while waiting
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    @(negedge clk);
    checks++;
    if ({imem_req, InstrValidF} !== 2'b00) begin
      errors++;
      $display("FAIL redir_c9: got req=%b vld=%b expected 0 0", imem_req, InstrValidF);
    end
    next_cycle();                    // c10: draining in DISCARD
    PCSrcE = 1'b0;
    @(negedge clk);
    checks++;
    if ({dbg_state, PCF, InstrValidF, imem_req} !== {2'd3, 32'h100, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL redir_discard: got st=%0d pc=%h vld=%b req=%b expected 3 100 0 0",
               dbg_state, PCF, InstrValidF, imem_req);
    end
    next_cycle();                    // c11: stale 0x8 response arrives
    @(negedge clk);
    checks++;
    if ({InstrValidF, InstrF} !== {1'b0, NOP}) begin
      errors++;
      $display("FAIL redir_drop: got vld=%b instr=%h expected 0 %h", InstrValidF, InstrF, NOP);
    end
    next_cycle();                    // c12
    @(negedge clk);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
      errors++;
      $display("FAIL redir_new_req: got req=%b addr=%h expected 1 100", imem_req, imem_addr);
    end
    cycles(3);                       // c15
    @(negedge clk);
    checks++;
    if ({InstrValidF, InstrF, PCF} !== {1'b1, 32'h00AB_0100, 32'h100}) begin
      errors++;
      $display("FAIL redir_target_data: got vld=%b instr=%h pc=%h expected 1 00ab0100 100",
               InstrValidF, InstrF, PCF);
    end
  endtask

  task automatic test_redirect_on_valid;
    apply_reset(1, 32'h5500_0000);
    next_cycle();                    // c1: response + redirect + stall together
    PCSrcE = 1'b1; StallF = 1'b1; PCTargetE = 32'h202;
    @(negedge clk);
    checks++;
    if ({InstrValidF, FetchBusyF, InstrF} !== {1'b0, 1'b1, NOP}) begin
      errors++;
      $display("FAIL rov_drop: got vld=%b busy=%b instr=%h expected 0 1 %h",
               InstrValidF, FetchBusyF, InstrF, NOP);
    end
    next_cycle();                    // c2
    PCSrcE = 1'b0; StallF = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_req, imem_addr, dbg_state} !== {1'b1, 32'h202, 2'd0}) begin
      errors++;
      $display("FAIL rov_req: got req=%b addr=%h st=%0d expected 1 202 0",
               imem_req, imem_addr, dbg_state);
    end
    next_cycle();                    // c3
    @(negedge clk);
    checks++;
    if ({InstrValidF, InstrF, PCF, PCPlus4F} !== {1'b1, 32'h5500_0202, 32'h202, 32'h206}) begin
      errors++;
      $display("FAIL rov_data: got vld=%b instr=%h pc=%h pc4=%h expected 1 55000202 202 206",
               InstrValidF, InstrF, PCF, PCPlus4F);
    end
  endtask

  task automatic test_pc_wrap;
    apply_reset(1, 32'h0F0F_0000);
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;   // c0: redirect in ISSUE
    @(negedge clk);
    checks++;
    if ({imem_req, InstrValidF} !== 2'b00) begin
      errors++;
      $display("FAIL wrap_issue_redir: got req=%b vld=%b expected 0 0", imem_req, InstrValidF);
    end
    next_cycle();                    // c1
    PCSrcE = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL wrap_req: got req=%b addr=%h expected 1 fffffffc", imem_req, imem_addr);
    end
    next_cycle();                    // c2
    @(negedge clk);
    checks++;
    if ({InstrValidF, InstrF, PCF, PCPlus4F} !== {1'b1, 32'hF0F0_FFFC, 32'hFFFF_FFFC, 32'h0}) begin
      errors++;
      $display("FAIL wrap_data: got vld=%b instr=%h pc=%h pc4=%h expected 1 f0f0fffc fffffffc 0",
               InstrValidF, InstrF, PCF, PCPlus4F);
    end
    next_cycle();                    // c3
    @(negedge clk);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL wrap_next_req: got req=%b addr=%h expected 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid_request;
    apply_reset(3, 32'h0000_7700);
    PCSrcE = 1'b1; PCTargetE = 32'h40;           // c0
    next_cycle();                    // c1: request to 0x40
    PCSrcE = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin
      errors++;
      $display("FAIL rmid_req: got req=%b addr=%h expected 1 40", imem_req, imem_addr);
    end
    next_cycle();                    // c2: reset while waiting; memory keeps its response
    mem_rst_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({imem_req, InstrValidF, InstrF} !== {1'b0, 1'b0, NOP}) begin
      errors++;
      $display("FAIL rmid_in_reset: got req=%b vld=%b instr=%h expected 0 0 %h",
               imem_req, InstrValidF, InstrF, NOP);
    end
    cycles(2);                       // c4: response arrives during reset
    @(negedge clk);
    checks++;
    if ({imem_req, InstrValidF, InstrF} !== {1'b0, 1'b0, NOP}) begin
      errors++;
      $display("FAIL rmid_resp_ignored: got req=%b vld=%b instr=%h expected 0 0 %h",
               imem_req, InstrValidF, InstrF, NOP);
    end
    next_cycle();                    // c5
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_req, imem_addr, PCF, InstrValidF} !== {1'b1, 32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL rmid_restart: got req=%b addr=%h pc=%h vld=%b expected 1 0 0 0",
               imem_req, imem_addr, PCF, InstrValidF);
    end
    next_cycle();                    // c6
    mem_rst_en = 1'b1;
    @(negedge clk);
    checks++;
    if ({dbg_state, InstrValidF} !== {2'd1, 1'b0}) begin
      errors++;
      $display("FAIL rmid_wait: got st=%0d vld=%b expected 1 0", dbg_state, InstrValidF);
    end
    cycles(2);                       // c8
    @(negedge clk);
    checks++;
    if ({InstrValidF, InstrF, PCF} !== {1'b1, 32'h0000_7700, 32'h0}) begin
      errors++;
      $display("FAIL rmid_data: got vld=%b instr=%h pc=%h expected 1 00007700 0",
               InstrValidF, InstrF, PCF);
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_counters;
    apply_reset(1, 32'h0);
    next_cycle();                    // c1: response, stall begins
    StallF = 1'b1;
    cycles(3);                       // c4: release
    StallF = 1'b0;
    @(negedge clk);
    checks++;
    if ({FetchCountF, StallCountF} !== {32'd0, 32'd3}) begin
      errors++;
      $display("FAIL perf_after_stall: got fetch=%0d stall=%0d expected 0 3", FetchCountF, StallCountF);
    end
    cycles(19);                      // c23: ten accepts done
    @(negedge clk);
    checks++;
    if ({FetchCountF, StallCountF} !== {32'd10, 32'd3}) begin
      errors++;
      $display("FAIL perf_final: got fetch=%0d stall=%0d expected 10 3", FetchCountF, StallCountF);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    test_reset();
    test_latency1();
    test_stall();
    test_redirect_wait();
    test_redirect_on_valid();
    test_pc_wrap();
    test_reset_mid_request();
`ifdef FETCH_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
